// File: rtl/mem_addr_gen.sv
// Registered memory-address source mux with an exception-vector byte fetch sequencer.
// Optional alignment check of selected addresses is built when MEM_ADDR_ALIGN_CHK_EN is defined.
module mem_addr_gen #(
  parameter int ADDR_W   = 32,
  parameter int N_SRC    = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                src_sel,
  input  logic [N_SRC*ADDR_W-1:0]   src_data,
  input  logic                      exc_req,
  input  logic [1:0]                exc_code,
  input  logic [7:0]                mem_rdata,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      exc_busy,
  output logic                      handler_valid,
  output logic [ADDR_W-1:0]         handler_addr,
  output logic                      sel_err,
  output logic                      addr_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n, hnd_n, sel_val;
  logic              busy_n, valid_n, err_n, sel_ok, do_sel, vec_load;

  always_comb begin
    sel_val = '0;
    sel_ok  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_sel == 3'(i)) begin
        sel_val = src_data[i*ADDR_W +: ADDR_W];
        sel_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    addr_n   = addr_out;
    hnd_n    = handler_addr;
    busy_n   = exc_busy;
    valid_n  = 1'b0;
    err_n    = sel_err;
    do_sel   = 1'b0;
    vec_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (exc_req && exc_code != 2'd3) begin
          addr_n   = ADDR_W'(VEC_BASE) + ADDR_W'(exc_code);
          cnt_n    = 3'(MEM_LAT - 1);
          busy_n   = 1'b1;
          vec_load = 1'b1;
          state_n  = S_WAIT;
        end else begin
          if (exc_req) err_n = 1'b1;
          do_sel = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) begin
          hnd_n   = ADDR_W'(mem_rdata);
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      S_DONE: begin
        do_sel  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Normal selection is shared by IDLE and DONE; a bad select holds addr_out.
    if (do_sel) begin
      if (sel_ok) addr_n = sel_val;
      else        err_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_out      <= '0;
      exc_busy      <= 1'b0;
      handler_valid <= 1'b0;
      handler_addr  <= '0;
      sel_err       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      addr_out      <= addr_n;
      exc_busy      <= busy_n;
      handler_valid <= valid_n;
      handler_addr  <= hnd_n;
      sel_err       <= err_n;
    end
  end

`ifdef MEM_ADDR_ALIGN_CHK_EN
  // Vector byte fetches are exempt; the flag only tracks selected word addresses.
  always_ff @(posedge clk) begin
    if (reset)
      addr_misaligned <= 1'b0;
    else if (vec_load)
      addr_misaligned <= 1'b0;
    else if (do_sel && sel_ok)
      addr_misaligned <= (sel_val[1:0] != 2'b00);
  end
`else
  assign addr_misaligned = 1'b0;
  logic unused_align;
  assign unused_align = vec_load;
`endif

endmodule

// File: tb/tb_mem_addr_gen.sv
// Directed bench for mem_addr_gen: a default instance (MEM_LAT=1) and a MEM_LAT=3 instance.
module tb_mem_addr_gen;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [3*AW-1:0] src_data;

  logic [2:0]    src_sel,  src_sel3;
  logic          exc_req,  exc_req3;
  logic [1:0]    exc_code, exc_code3;
  logic [7:0]    mem_rdata, mem_rdata3;

  logic [AW-1:0] addr_out, addr_out3, handler_addr, handler_addr3;
  logic          exc_busy, exc_busy3, handler_valid, handler_valid3;
  logic          sel_err, sel_err3, addr_misaligned, addr_misaligned3;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;

`ifdef MEM_ADDR_ALIGN_CHK_EN
  localparam logic ALN = 1'b1;
`else
  localparam logic ALN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_addr_gen #(.ADDR_W(AW), .N_SRC(3), .VEC_BASE(253), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data),
    .exc_req(exc_req), .exc_code(exc_code), .mem_rdata(mem_rdata),
    .addr_out(addr_out), .exc_busy(exc_busy), .handler_valid(handler_valid),
    .handler_addr(handler_addr), .sel_err(sel_err), .addr_misaligned(addr_misaligned)
  );

  mem_addr_gen #(.ADDR_W(AW), .N_SRC(3), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .src_sel(src_sel3), .src_data(src_data),
    .exc_req(exc_req3), .exc_code(exc_code3), .mem_rdata(mem_rdata3),
    .addr_out(addr_out3), .exc_busy(exc_busy3), .handler_valid(handler_valid3),
    .handler_addr(handler_addr3), .sel_err(sel_err3), .addr_misaligned(addr_misaligned3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [AW-1:0] a, input logic busy,
                      input logic valid, input logic [AW-1:0] h, input logic err, input logic mis);
    chk({tag, ".addr"},  addr_out,              a);
    chk({tag, ".busy"},  AW'(exc_busy),         AW'(busy));
    chk({tag, ".valid"}, AW'(handler_valid),    AW'(valid));
    chk({tag, ".hnd"},   handler_addr,          h);
    chk({tag, ".err"},   AW'(sel_err),          AW'(err));
    chk({tag, ".mis"},   AW'(addr_misaligned),  AW'(mis));
  endtask

  task automatic chk3(input string tag, input logic [AW-1:0] a, input logic busy,
                      input logic valid, input logic [AW-1:0] h, input logic err);
    chk({tag, ".addr"},  addr_out3,            a);
    chk({tag, ".busy"},  AW'(exc_busy3),       AW'(busy));
    chk({tag, ".valid"}, AW'(handler_valid3),  AW'(valid));
    chk({tag, ".hnd"},   handler_addr3,        h);
    chk({tag, ".err"},   AW'(sel_err3),        AW'(err));
  endtask

  initial begin
    reset = 1'b1;
    src_data = {32'h0000_1002, 32'h0000_1000, 32'h0000_0040};
    src_sel = 3'd0; exc_req = 1'b0; exc_code = 2'd0; mem_rdata = 8'h00;
    src_sel3 = 3'd0; exc_req3 = 1'b0; exc_code3 = 2'd0; mem_rdata3 = 8'h00;
    step(); step();
    chk1("rst", 32'h0, 0, 0, 32'h0, 0, 0);
    chk3("rst3", 32'h0, 0, 0, 32'h0, 0);

    // normal selection and out-of-range select
    reset = 1'b0;
    step();             chk1("sel0", 32'h40, 0, 0, 0, 0, 0);
    src_sel = 3'd1; step(); chk1("sel1", 32'h1000, 0, 0, 0, 0, 0);
    src_sel = 3'd5; step(); chk1("sel5", 32'h1000, 0, 0, 0, 1, 0);
    src_sel = 3'd3; step(); chk1("sel3", 32'h1000, 0, 0, 0, 1, 0);
    src_sel = 3'd2; step(); chk1("sel2", 32'h1002, 0, 0, 0, 1, ALN);
    src_data[2*AW +: AW] = 32'h0000_1004;
    step();             chk1("sel2b", 32'h1004, 0, 0, 0, 1, 0);
    src_data[2*AW +: AW] = 32'h0000_1002;
    step();             chk1("sel2c", 32'h1002, 0, 0, 0, 1, ALN);

    // exception code 1, MEM_LAT=1
    exc_req = 1'b1; exc_code = 2'd1; mem_rdata = 8'h8C;
    step();             chk1("vec1", 32'd254, 1, 0, 0, 1, 0);
    exc_req = 1'b0;
    step();             chk1("cap1", 32'd254, 0, 1, 32'h8C, 1, 0);
    step();             chk1("done1", 32'h1002, 0, 0, 32'h8C, 1, ALN);
    step();             chk1("idle1", 32'h1002, 0, 0, 32'h8C, 1, ALN);

    // reserved code: ignored, flags sel_err
    reset = 1'b1; step(); chk1("rst2", 32'h0, 0, 0, 0, 0, 0);
    reset = 1'b0; src_sel = 3'd0; exc_req = 1'b1; exc_code = 2'd3;
    step();             chk1("res3", 32'h40, 0, 0, 0, 1, 0);
    exc_req = 1'b0;
    step();             chk1("res3b", 32'h40, 0, 0, 0, 1, 0);

    // code 0 from a misaligned selection: vector load clears misaligned flag
    reset = 1'b1; step();
    reset = 1'b0; src_sel = 3'd2;
    step();             chk1("pre0", 32'h1002, 0, 0, 0, 0, ALN);
    exc_req = 1'b1; exc_code = 2'd0;
    step();             chk1("vec0", 32'd253, 1, 0, 0, 0, 0);
    exc_req = 1'b0; mem_rdata = 8'hFF;
    step();             chk1("cap0", 32'd253, 0, 1, 32'hFF, 0, 0);
    step();             chk1("done0", 32'h1002, 0, 0, 32'hFF, 0, ALN);

    // MEM_LAT=3 instance, code 2, select toggling and a second request ignored in WAIT
    reset = 1'b1; step();
    reset = 1'b0; src_sel3 = 3'd0;
    step();             chk3("l3sel", 32'h40, 0, 0, 0, 0);
    exc_req3 = 1'b1; exc_code3 = 2'd2; mem_rdata3 = 8'h11;
    step();             chk3("l3T", 32'd255, 1, 0, 0, 0);
    exc_req3 = 1'b0; src_sel3 = 3'd1;
    step();             chk3("l3T1", 32'd255, 1, 0, 0, 0);
    exc_req3 = 1'b1; exc_code3 = 2'd0; src_sel3 = 3'd2;
    step();             chk3("l3T2", 32'd255, 1, 0, 0, 0);
    exc_req3 = 1'b0; mem_rdata3 = 8'h5A; src_sel3 = 3'd1;
    step();             chk3("l3T3", 32'd255, 0, 1, 32'h5A, 0);
    step();             chk3("l3done", 32'h1000, 0, 0, 32'h5A, 0);
    step();             chk3("l3idle", 32'h1000, 0, 0, 32'h5A, 0);

    // reset in WAIT aborts without a handler pulse
    exc_req3 = 1'b1; exc_code3 = 2'd1;
    step();             chk3("abT", 32'd254, 1, 0, 32'h5A, 0);
    exc_req3 = 1'b0; reset = 1'b1;
    step();             chk3("abrst", 32'h0, 0, 0, 32'h0, 0);
    reset = 1'b0;
    step();             chk3("ab1", 32'h1000, 0, 0, 32'h0, 0);
    step();             chk3("ab2", 32'h1000, 0, 0, 32'h0, 0);
    step();             chk3("ab3", 32'h1000, 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_addr_gen.md
Name: mem_addr_gen

Overview:
- Parametrised, registered successor to the memory-address source mux of the multicycle CPU datapath.
- Selects the memory address from N_SRC datapath sources, for example PC, ALUOut and the B register.
- Contains an exception-vector fetch sequencer. It drives the vector byte address (VEC_BASE+code), waits out the memory read latency, captures the handler byte and hands a zero-extended handler address to the PC path.
- Sits between the control unit / datapath registers and the memory address port.

Parameters:
- ADDR_W, 32, width of all address buses.
- N_SRC, 3, number of datapath address sources (1..7).
- VEC_BASE, 253, byte address of vector for exc_code 0. Codes 1 and 2 use VEC_BASE+1 and VEC_BASE+2.
- MEM_LAT, 1, cycles from addr_out change to valid mem_rdata (1..7).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- src_sel, input, 3, source select: 0..N_SRC-1 valid.
- src_data, input, N_SRC*ADDR_W, flattened sources; source i occupies bits [i*ADDR_W +: ADDR_W].
- exc_req, input, 1, exception request, sampled in IDLE only.
- exc_code, input, 2, 0=invalid opcode, 1=overflow, 2=div-by-zero, 3=reserved.
- mem_rdata, input, 8, byte read from memory.
- addr_out, output, ADDR_W, registered memory address.
- exc_busy, output, 1, high while the vector fetch is in progress.
- handler_valid, output, 1, one-cycle pulse: handler_addr is valid.
- handler_addr, output, ADDR_W, zero-extended mem_rdata captured at the end of the fetch.
- sel_err, output, 1, sticky flag: out-of-range src_sel or exc_code 3 was seen.
- addr_misaligned, output, 1, see Optional Feature.

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - reset has priority over everything. It is synchronous, so its effect appears at the next rising edge.
  - Reset values: state=IDLE, wait counter=0, addr_out=0, exc_busy=0, handler_valid=0, handler_addr=0, sel_err=0, addr_misaligned=0.
  - Reset mid-fetch aborts the fetch with no handler_valid pulse.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If exc_req=1 and exc_code<3: addr_out <= VEC_BASE+exc_code, counter <= MEM_LAT-1, exc_busy <= 1, go to WAIT.
  - If exc_req=1 and exc_code=3: request ignored, sel_err <= 1, stay in IDLE. addr_out follows src_sel as in normal operation.
  - Otherwise, normal operation:
    - If src_sel<N_SRC: addr_out <= source[src_sel].
    - If src_sel>=N_SRC: addr_out holds its previous value and sel_err <= 1.
  - exc_req has priority over src_sel in the same cycle.
- WAIT:
  - addr_out is held and src_sel is ignored.
  - If counter=0: handler_addr <= {zeros, mem_rdata}, handler_valid <= 1, exc_busy <= 0, go to DONE.
  - Otherwise decrement the counter.
  - exc_req is ignored (no queueing).
- DONE:
  - handler_valid <= 0. Normal src_sel selection resumes the same cycle. Go to IDLE.
  - exc_req is ignored in DONE, so a back-to-back exception needs exc_req held to the IDLE cycle.
- Timing:
  - Normal path latency: 1 cycle, src_sel/src_data to addr_out.
  - Exception path: exc_req sampled at edge T, so addr_out=vector from T. mem_rdata is captured at edge T+MEM_LAT, and handler_valid is high for exactly the cycle after edge T+MEM_LAT.
  - exc_busy is high from edge T to edge T+MEM_LAT.
- Width rules:
  - Vector arithmetic is done in ADDR_W bits, with no wrap for legal parameters.
  - handler_addr bits above bit 7 are always 0.
- sel_err clears only on reset.

Optional Feature:
- Macro: MEM_ADDR_ALIGN_CHK_EN.
- Defined: addr_misaligned <= (next addr_out[1:0] != 0) in normal selection, updated with addr_out. It is forced to 0 when loading a vector address, because byte fetches are exempt.
- Undefined: addr_misaligned is tied to 0 and no check logic is built.

Test Plan:
- Reset, then src_sel=0 with source0=0x00000040 -> addr_out=0x40 one cycle later; all flags 0.
- N_SRC=3, source1=0x1000 then src_sel=1 -> addr_out=0x1000. Next, src_sel=5 -> addr_out stays 0x1000 and sel_err=1 (sticky until reset).
- MEM_LAT=1, exc_req=1 with exc_code=1 in IDLE:
  - addr_out=254 next cycle and exc_busy=1.
  - With mem_rdata=0x8C: handler_addr=0x0000008C, handler_valid pulses for 1 cycle, exc_busy falls.
- MEM_LAT=3, exc_code=2:
  - addr_out=255 for 3 cycles while src_sel toggles (ignored).
  - A second exc_req during WAIT is ignored.
  - handler_valid fires exactly once, 3 edges after the request.
- exc_code=3 -> no fetch, exc_busy stays 0, sel_err=1. Separately, reset asserted in WAIT -> next edge: IDLE, addr_out=0, no handler_valid pulse.
- With MEM_ADDR_ALIGN_CHK_EN defined:
  - src_sel selects 0x1002 -> addr_misaligned=1.
  - 0x1004 -> 0.
  - Vector fetch at 253 -> 0.
